bus_transfer_controller: RTL and testbench

- Bus-side initiator for the 8-bit general registers.
- Sequences one register-to-register (or external-to-register) transfer per request.
- Drives the per-register read_data/write_data strobes and the shared data bus that the registers sample on the falling clock edge.
- Sits between the instruction decoder (request side) and the register bank (strobe/bus side).

---
 rtl/bus_transfer_controller.sv | 136 +++++++++++++
 tb/tb_bus_transfer_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller: bus-side initiator for the general registers.
// Runs one register-to-register (or external-to-register) transfer per
// request. It drives one-hot read/write strobes and a shared data bus, and
// the registers sample these on the falling clock edge.
// Optional feature macro: TRANSFER_COUNT_EN adds a 16-bit count of
// completed transfers that had no select error.
module bus_transfer_controller #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SEL_W-1:0]           src_sel,
  input  logic [SEL_W-1:0]           dst_sel,
  input  logic                       ext_write,
  input  logic [DATA_W-1:0]          ext_data,
  input  logic [NUM_REGS*DATA_W-1:0] reg_values,
  output logic [NUM_REGS-1:0]        read_data,
  output logic [NUM_REGS-1:0]        write_data,
  output logic [DATA_W-1:0]          data_bus,
  output logic                       busy,
  output logic                       done,
  output logic                       sel_error
`ifdef TRANSFER_COUNT_EN
  ,
  output logic [15:0]                xfer_count
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state, state_n;
  logic [SEL_W-1:0]    src_q, dst_q;
  logic [NUM_REGS-1:0] rd_n, wr_n;
  logic [DATA_W-1:0]   bus_n;
  logic                busy_n, done_n, err_n;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (idx == SEL_W'(i)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic in_range(input logic [SEL_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Capture the request selects on the accepting edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
    end else if (state == IDLE && start) begin
      src_q <= src_sel;
      dst_q <= dst_sel;
    end
  end

  // State register plus registered outputs (strobes come straight from flops)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      read_data  <= '0;
      write_data <= '0;
      data_bus   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sel_error  <= 1'b0;
    end else begin
      state      <= state_n;
      read_data  <= rd_n;
      write_data <= wr_n;
      data_bus   <= bus_n;
      busy       <= busy_n;
      done       <= done_n;
      sel_error  <= err_n;
    end
  end

  // Next state and next output values; outputs are decoded from the state
  // being entered so they line up with that state once registered
  always_comb begin
    state_n = state;
    rd_n    = '0;
    wr_n    = '0;
    bus_n   = data_bus;
    err_n   = sel_error;
    case (state)
      IDLE: begin
        err_n = 1'b0;
        if (start) begin
          if (!in_range(dst_sel) || (!ext_write && !in_range(src_sel))) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else if (ext_write) begin
            state_n = WRITE;
            bus_n   = ext_data;
            wr_n    = onehot(dst_sel);
          end else begin
            state_n = READ;
            rd_n    = onehot(src_sel);
          end
        end
      end
      READ: begin
        state_n = WRITE;
        wr_n    = onehot(dst_q);
        for (int unsigned i = 0; i < NUM_REGS; i++)
          if (src_q == SEL_W'(i)) bus_n = reg_values[i*DATA_W +: DATA_W];
      end
      WRITE: state_n = DONE;
      DONE: begin
        state_n = IDLE;
        err_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

`ifdef TRANSFER_COUNT_EN
  // Count successful transfers as they leave DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      xfer_count <= '0;
    else if (state == DONE && !sel_error)
      xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Self-checking bench for bus_transfer_controller: a 4-register instance (a)
// and a 3-register instance (b) that can exercise out-of-range selects.
module tb_bus_transfer_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  src_sel = '0, dst_sel = '0;
  logic        ext_write = 1'b0;
  logic [7:0]  ext_data = '0;
  logic [7:0]  regs [4];
  logic [31:0] vals_a;
  logic [23:0] vals_b;

  logic [3:0]  rd_a, wr_a;
  logic [2:0]  rd_b, wr_b;
  logic [7:0]  bus_a_o, bus_b_o;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [18:0] obs_a, obs_b;

  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  bus_a = '0, bus_b = '0;
  int          cnt_a = 0, cnt_b = 0;

`ifdef TRANSFER_COUNT_EN
  logic [15:0] xc_a, xc_b;
`endif

  always #5 clock = ~clock;

  assign vals_a = {regs[3], regs[2], regs[1], regs[0]};
  assign vals_b = vals_a[23:0];
  assign obs_a  = {rd_a, wr_a, bus_a_o, busy_a, done_a, err_a};
  assign obs_b  = {1'b0, rd_b, 1'b0, wr_b, bus_b_o, busy_b, done_b, err_b};

  bus_transfer_controller #(.NUM_REGS(4), .SEL_W(2), .DATA_W(8)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .src_sel(src_sel),
    .dst_sel(dst_sel), .ext_write(ext_write), .ext_data(ext_data),
    .reg_values(vals_a), .read_data(rd_a), .write_data(wr_a),
    .data_bus(bus_a_o), .busy(busy_a), .done(done_a), .sel_error(err_a)
`ifdef TRANSFER_COUNT_EN
    , .xfer_count(xc_a)
`endif
  );

  bus_transfer_controller #(.NUM_REGS(3), .SEL_W(2), .DATA_W(8)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .src_sel(src_sel),
    .dst_sel(dst_sel), .ext_write(ext_write), .ext_data(ext_data),
    .reg_values(vals_b), .read_data(rd_b), .write_data(wr_b),
    .data_bus(bus_b_o), .busy(busy_b), .done(done_b), .sel_error(err_b)
`ifdef TRANSFER_COUNT_EN
    , .xfer_count(xc_b)
`endif
  );

  // Expected {read,write,bus,busy,done,err} in cycle cyc (1 = the cycle after
  // the edge that accepts start), derived from the latency rules
  function automatic logic [18:0] model(input int cyc, input int src, input int dst,
                                        input bit ext, input logic [7:0] data,
                                        input logic [7:0] val, input logic [7:0] prev,
                                        input int nregs);
    bit         bad;
    int         lat;
    logic [3:0] rd, wr;
    logic [7:0] bus;
    bad = (dst >= nregs) || (!ext && src >= nregs);
    lat = bad ? 1 : (ext ? 2 : 3);
    rd  = (!bad && !ext && cyc == 1) ? 4'(1 << src) : 4'b0;
    wr  = (!bad && cyc == lat - 1) ? 4'(1 << dst) : 4'b0;
    if (bad)      bus = prev;
    else if (ext) bus = data;
    else          bus = (cyc == 1) ? prev : val;
    return {rd, wr, bus, 1'(cyc <= lat), 1'(cyc == lat), 1'(bad && cyc == lat)};
  endfunction

  // Present a request and let the accepting edge pass (stimulus only)
  task automatic issue(input bit on_b, input int src, input int dst,
                       input bit ext, input logic [7:0] data);
    src_sel   = 2'(src);
    dst_sel   = 2'(dst);
    ext_write = ext;
    ext_data  = data;
    if (on_b) start_b = 1'b1;
    else      start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    logic [18:0] e;
    randomize_regs();
    #1 reset = 1'b0;
    #2;
    n_cmp++;
    if (obs_a !== 19'd0) begin n_bad++; $display("FAIL reset_a: got %h expected %h", obs_a, 19'd0); end
    n_cmp++;
    if (obs_b !== 19'd0) begin n_bad++; $display("FAIL reset_b: got %h expected %h", obs_b, 19'd0); end
    @(negedge clock);
    reset = 1'b1;
    e = '0;
    @(negedge clock);
    n_cmp++;
    if (obs_a !== e) begin n_bad++; $display("FAIL reset_idle_a: got %h expected %h", obs_a, e); end
  endtask

  task automatic test_reg_transfer();
    logic [18:0] e;
    randomize_regs();
    regs[2] = 8'hA5;
    issue(0, 2, 0, 0, 8'($urandom));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      e = model(c, 2, 0, 0, 8'h00, regs[2], bus_a, 4);
      n_cmp++;
      if (obs_a !== e) begin n_bad++; $display("FAIL reg_xfer cyc%0d: got %h expected %h", c, obs_a, e); end
    end
    bus_a = 8'hA5;
    cnt_a++;
  endtask

  task automatic test_ext_write();
    logic [18:0] e;
    int          s;
    s = $urandom_range(0, 3);
    issue(0, s, 3, 1, 8'h3C);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      e = model(c, s, 3, 1, 8'h3C, regs[s], bus_a, 4);
      n_cmp++;
      if (obs_a !== e) begin n_bad++; $display("FAIL ext_write cyc%0d: got %h expected %h", c, obs_a, e); end
    end
    bus_a = 8'h3C;
    cnt_a++;
  endtask

  task automatic test_sel_error();
    logic [18:0] e;
    int          src_t [4] = '{0, 3, 1, 3};
    int          dst_t [4] = '{3, 1, 3, 1};
    bit          ext_t [4] = '{0, 0, 1, 1};
    logic [7:0]  d;
    randomize_regs();
    for (int t = 0; t < 4; t++) begin
      d = 8'($urandom);
      issue(1, src_t[t], dst_t[t], ext_t[t], d);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clock);
        e = model(c, src_t[t], dst_t[t], ext_t[t], d, regs[src_t[t]], bus_b, 3);
        n_cmp++;
        if (obs_b !== e) begin n_bad++; $display("FAIL sel_error t%0d cyc%0d: got %h expected %h", t, c, obs_b, e); end
      end
      e = model(4, src_t[t], dst_t[t], ext_t[t], d, regs[src_t[t]], bus_b, 3);
      bus_b = e[10:3];
      if (!(dst_t[t] >= 3 || (!ext_t[t] && src_t[t] >= 3))) cnt_b++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rd, exp_wr;
    logic       exp_done;
    randomize_regs();
    src_sel = 2'd1;
    dst_sel = 2'd2;
    ext_write = 1'b0;
    start_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clock);
      if (k == 12) begin #1 start_a = 1'b0; end
      @(negedge clock);
      exp_rd   = (k % 4 == 1 && k < 12) ? 4'b0010 : 4'b0000;
      exp_wr   = (k % 4 == 2 && k < 12) ? 4'b0100 : 4'b0000;
      exp_done = (k % 4 == 3);
      n_cmp++;
      if ({rd_a, wr_a, done_a} !== {exp_rd, exp_wr, exp_done}) begin
        n_bad++;
        $display("FAIL back_to_back k%0d: got rd=%b wr=%b done=%b expected rd=%b wr=%b done=%b",
                 k, rd_a, wr_a, done_a, exp_rd, exp_wr, exp_done);
      end
    end
    n_cmp++;
    if (bus_a_o !== regs[1]) begin n_bad++; $display("FAIL back_to_back_bus: got %h expected %h", bus_a_o, regs[1]); end
    bus_a = regs[1];
    cnt_a += 3;
  endtask

  task automatic test_random();
    logic [18:0] e;
    int          s, d;
    bit          x, on_b;
    logic [7:0]  v;
    for (int n = 0; n < 24; n++) begin
      randomize_regs();
      s = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      x = 1'($urandom);
      v = 8'($urandom);
      on_b = n[0];
      issue(on_b, s, d, x, v);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clock);
        if (on_b) begin
          e = model(c, s, d, x, v, regs[s], bus_b, 3);
          n_cmp++;
          if (obs_b !== e) begin n_bad++; $display("FAIL random_b n%0d cyc%0d: got %h expected %h", n, c, obs_b, e); end
        end else begin
          e = model(c, s, d, x, v, regs[s], bus_a, 4);
          n_cmp++;
          if (obs_a !== e) begin n_bad++; $display("FAIL random_a n%0d cyc%0d: got %h expected %h", n, c, obs_a, e); end
        end
      end
      if (on_b) begin
        e = model(4, s, d, x, v, regs[s], bus_b, 3);
        bus_b = e[10:3];
        if (!(d >= 3 || (!x && s >= 3))) cnt_b++;
      end else begin
        e = model(4, s, d, x, v, regs[s], bus_a, 4);
        bus_a = e[10:3];
        cnt_a++;
      end
    end
  endtask

  task automatic test_count();
`ifdef TRANSFER_COUNT_EN
    n_cmp++;
    if (xc_a !== 16'(cnt_a)) begin n_bad++; $display("FAIL count_a: got %0d expected %0d", xc_a, cnt_a); end
    n_cmp++;
    if (xc_b !== 16'(cnt_b)) begin n_bad++; $display("FAIL count_b: got %0d expected %0d", xc_b, cnt_b); end
`endif
  endtask

  task automatic test_reset_mid_read();
    logic [18:0] e;
    randomize_regs();
    issue(0, 1, 3, 0, 8'h00);
    @(negedge clock);
    n_cmp++;
    if (rd_a !== 4'b0010) begin n_bad++; $display("FAIL mid_read_strobe: got %b expected %b", rd_a, 4'b0010); end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (obs_a !== 19'd0) begin n_bad++; $display("FAIL mid_read_reset: got %h expected %h", obs_a, 19'd0); end
    @(negedge clock);
    reset = 1'b1;
    bus_a = '0;
    bus_b = '0;
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_cmp++;
      if (obs_a !== 19'd0) begin n_bad++; $display("FAIL post_reset_idle c%0d: got %h expected %h", c, obs_a, 19'd0); end
    end
    issue(0, 0, 2, 1, 8'h5A);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      e = model(c, 0, 2, 1, 8'h5A, regs[0], bus_a, 4);
      n_cmp++;
      if (obs_a !== e) begin n_bad++; $display("FAIL post_reset_xfer cyc%0d: got %h expected %h", c, obs_a, e); end
    end
    bus_a = 8'h5A;
    cnt_a++;
  endtask

  initial begin
    test_reset();
    test_reg_transfer();
    test_ext_write();
    test_sel_error();
    test_back_to_back();
    test_random();
    test_count();
    test_reset_mid_read();
    test_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
